// File: rtl/line_mem.sv
// line_mem: whole-line memory with a fixed-latency level request / one-cycle gnt handshake
// Ports: clk, rst (async, active high); addr, rd_req, wr_req, wr_line in; gnt, rd_line out.
// Build option: define LINE_MEM_RST_CLEAR_EN to make rst also clear every stored word.
module line_mem #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 7,
  parameter int LATENCY       = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                gnt,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  output logic [31:0]         rd_line [2**LINE_ADDR_LEN],
  input  logic                wr_req,
  input  logic [31:0]         wr_line [2**LINE_ADDR_LEN]
);
  localparam int LINE_SIZE = 2**LINE_ADDR_LEN;
  localparam logic [7:0] L_END = 8'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic r_wr, w_idle, w_wr, w_enter, w_hold;
  logic [ADDR_LEN-1:0] r_addr, w_addr;
  logic [31:0] r_line [LINE_SIZE];
  logic [31:0] w_line [LINE_SIZE];
  logic [31:0] r_mem [2**ADDR_LEN][LINE_SIZE];
  // With LATENCY==1 the commit happens on the acceptance edge, so it must use the live inputs.
  assign w_idle = r_state == IDLE;
  assign w_wr   = w_idle ? wr_req : r_wr;
  assign w_addr = w_idle ? addr : r_addr;
  assign w_hold = r_wr ? wr_req : rd_req;
  always_comb begin
    for (int i = 0; i < LINE_SIZE; i++) w_line[i] = w_idle ? wr_line[i] : r_line[i];
  end
  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      IDLE: if (wr_req || rd_req) begin
        if (LATENCY == 1) w_next = DONE;
        else w_next = BUSY;
        w_enter = LATENCY == 1;
      end
      BUSY: if (!w_hold) w_next = IDLE;
      else if (r_cnt == L_END) begin
        w_next  = DONE;
        w_enter = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      gnt     <= 1'b0;
      for (int i = 0; i < LINE_SIZE; i++) begin
        rd_line[i] <= '0;
        r_line[i]  <= '0;
      end
    end else begin
      r_state <= w_next;
      gnt     <= w_next == DONE;
      r_cnt   <= w_idle ? 8'd1 : r_cnt + 8'd1;
      if (w_idle) begin
        r_wr   <= wr_req;
        r_addr <= addr;
        if (wr_req) for (int i = 0; i < LINE_SIZE; i++) r_line[i] <= wr_line[i];
      end
      if (w_enter && !w_wr) for (int i = 0; i < LINE_SIZE; i++) rd_line[i] <= r_mem[w_addr][i];
    end
  end
`ifdef LINE_MEM_RST_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 2**ADDR_LEN; a++)
        for (int i = 0; i < LINE_SIZE; i++) r_mem[a][i] <= '0;
    end else if (w_enter && w_wr) begin
      for (int i = 0; i < LINE_SIZE; i++) r_mem[w_addr][i] <= w_line[i];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (w_enter && w_wr && !rst)
      for (int i = 0; i < LINE_SIZE; i++) r_mem[w_addr][i] <= w_line[i];
  end
`endif
endmodule

// File: tb/tb_line_mem.sv
// tb_line_mem: directed checks of the line_mem handshake, latency, abort and reset behaviour
module tb_line_mem;
  logic clk = 1'b0;
  logic rst, gnt, rd_req, wr_req;
  logic [6:0] addr;
  logic [31:0] rd_line [8];
  logic [31:0] wr_line [8];
  int n_tot = 0, n_bad = 0, cyc = 0;
  int lat, at1, at2, g;

  line_mem #(.LINE_ADDR_LEN(3), .ADDR_LEN(7), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .gnt(gnt), .addr(addr), .rd_req(rd_req),
    .rd_line(rd_line), .wr_req(wr_req), .wr_line(wr_line)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 8; i++) chk(tag, rd_line[i], base + step * 32'(i));
  endtask

  // Hold the request until gnt; scramble addr/wr_line right after acceptance to show they are latched.
  task automatic run(input logic w, input logic r, input logic [6:0] a, input logic [31:0] base,
                     input logic [31:0] step, output int l, output int at);
    @(negedge clk);
    addr = a;
    for (int i = 0; i < 8; i++) wr_line[i] = base + step * 32'(i);
    wr_req = w;
    rd_req = r;
    l = 0;
    do begin
      @(posedge clk); #1;
      l++;
      if (l == 1) begin
        addr = ~a;
        for (int i = 0; i < 8; i++) wr_line[i] = 32'hDEAD_0000 + 32'(i);
      end
    end while (!gnt && l < 20);
    at = cyc;
    chk("gnt_latency", l, 4);
    @(posedge clk); #1;
    chk("gnt_one_cycle", {31'd0, gnt}, 0);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic watch(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (gnt) cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; addr = '0;
    for (int i = 0; i < 8; i++) wr_line[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // known contents so the bench does not depend on the reset-clear build option
    run(1, 0, 7'h7F, 0, 0, lat, at1);
    run(1, 0, 7'h02, 0, 0, lat, at1);
    run(1, 0, 7'h30, 0, 0, lat, at1);
    run(1, 0, 7'h20, 0, 0, lat, at1);
    run(1, 0, 7'h11, 32'hB000_0000, 1, lat, at1);
    run(0, 1, 7'h11, 0, 0, lat, at1);
    check_line("pre_rd_11", 32'hB000_0000, 1);
    // asynchronous reset clears gnt and rd_line without a clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_gnt", {31'd0, gnt}, 0);
    check_line("rst_rd_line", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 1, 7'h7F, 0, 0, lat, at1);
    check_line("rd_7f_zero", 0, 0);
    run(1, 0, 7'h15, 32'hA000_0000, 1, lat, at1);
    run(0, 1, 7'h15, 0, 0, lat, at1);
    check_line("rd_15", 32'hA000_0000, 1);
    run(1, 1, 7'h02, 32'h1234_5678, 0, lat, at1);
    check_line("both_keep_rd", 32'hA000_0000, 1);
    run(0, 1, 7'h02, 0, 0, lat, at1);
    check_line("rd_02", 32'h1234_5678, 0);
    // write abandoned after two edges
    @(negedge clk);
    addr = 7'h30;
    for (int i = 0; i < 8; i++) wr_line[i] = 32'h5555_5555;
    wr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 wr_req = 1'b0;
    watch(10, g);
    chk("abort_no_gnt", g, 0);
    run(0, 1, 7'h30, 0, 0, lat, at1);
    check_line("rd_30_old", 0, 0);
    // back-to-back write then read
    run(1, 0, 7'h10, 32'hC000_0000, 1, lat, at1);
    run(0, 1, 7'h11, 0, 0, lat, at2);
    chk("b2b_gap_ge5", {31'd0, (at2 - at1) >= 5}, 1);
    check_line("rd_11", 32'hB000_0000, 1);
    run(0, 1, 7'h10, 0, 0, lat, at1);
    check_line("rd_10", 32'hC000_0000, 1);
    // reset in the middle of a write
    @(negedge clk);
    addr = 7'h20;
    for (int i = 0; i < 8; i++) wr_line[i] = 32'hFFFF_FFFF;
    wr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wr_req = 1'b0;
    #1 chk("rst_busy_gnt", {31'd0, gnt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch(10, g);
    chk("rst_abort_no_gnt", g, 0);
    run(0, 1, 7'h20, 0, 0, lat, at1);
    check_line("rd_20_zero", 0, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
